// File: rtl/sc_conv_pkg.sv
// Shared types and helpers for the stochastic-to-binary converter.
// Holds the FSM state encoding and the count-to-binary scaling function.
package sc_conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } conv_state_t;

    // Scale a ones count back to full precision and clamp to w bits.
    // A run of L = 2^(w-s) bits only overflows when every bit was 1.
    function automatic logic [31:0] sat_scale(
        input logic [31:0] count,
        input logic [31:0] s,
        input logic [31:0] w
    );
        logic [31:0] r;
        logic [31:0] lim;
        r   = count << s;
        lim = (32'd1 << w) - 32'd1;
        return (r > lim) ? lim : r;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Per-lane ones counter for the stochastic-to-binary converter.
// Clear has priority over enable so a new run always starts from zero.
module sc_ones_counter
    import sc_conv_pkg::*;
#(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_bit,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    // Accumulate one stream bit per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(i_bit);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sc_stoch_to_bin_et.sv
// Stochastic-to-binary converter with early termination.
// Counts ones per lane over 2^(WIDTH-s) valid bits, then rescales by s.
module sc_stoch_to_bin_et
    import sc_conv_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 8,
    parameter int SHW        = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SHW-1:0]        et_shift,
    input  logic                  bit_valid,
    input  logic [NUM_INPUTS-1:0] Xs,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      Bzs [NUM_INPUTS]
);

    localparam logic [SHW-1:0] W_S = SHW'(WIDTH);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    conv_state_t      r_state;
    logic [SHW-1:0]   r_s;
    logic [WIDTH:0]   r_smp;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_bzs [NUM_INPUTS];

    logic [SHW-1:0]   w_s_new;
    logic [WIDTH:0]   w_len;
    logic             w_accept;
    logic             w_take;
    logic             w_last;
    logic [WIDTH:0]   w_cnt [NUM_INPUTS];
    logic [WIDTH-1:0] w_res [NUM_INPUTS];

    // Shifts beyond WIDTH collapse to a single-bit run.
    assign w_s_new  = (et_shift > W_S) ? W_S : et_shift;
    assign w_len    = ONE << (W_S - r_s);
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_take   = (r_state == RUN) && bit_valid;
    assign w_last   = w_take && ((r_smp + ONE) == w_len);

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
        sc_ones_counter #(
            .CW (WIDTH + 1)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (w_accept),
            .i_en    (w_take),
            .i_bit   (Xs[g]),
            .o_count (w_cnt[g])
        );
    end

    // Final lane values include the bit arriving on the last sample.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_res[i] = WIDTH'(sat_scale(
                32'(w_cnt[i] + (WIDTH + 1)'(Xs[i])),
                32'(r_s),
                32'(WIDTH)));
        end
    end

    // Run control: latch shift, count samples, publish results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_smp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_bzs[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_s     <= w_s_new;
                        r_smp   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (w_take) begin
                        r_smp <= r_smp + ONE;
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            for (int i = 0; i < NUM_INPUTS; i++) begin
                                r_bzs[i] <= w_res[i];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Bzs  = r_bzs;

endmodule
